// File: rtl/prog_mem_pkg.sv
// Shared types and sizes for the serial-loaded program/data memory.
package prog_mem_pkg;

  typedef enum logic [2:0] {
    HDR  = 3'd0,
    DATA = 3'd1,
    CSUM = 3'd2,
    RUN  = 3'd3,
    ERR  = 3'd4
  } pm_state_t;

  localparam int PM_WORD_W = 15;
  localparam int PM_HDR_W  = 8;
  localparam int PM_CSUM_W = 8;
  localparam int PM_DEPTH  = 256;

endpackage

// File: rtl/prog_mem_loader_ser_shift.sv
// MSB-first serial-in shift register with a reloadable field bit counter.
// `word` already includes the bit offered this cycle, so it is complete when `done` pulses.
module ser_shift
  import prog_mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [3:0]           len,
  input  logic                 shift_en,
  input  logic                 bit_in,
  output logic [PM_WORD_W-1:0] word,
  output logic                 done
);

  logic [PM_WORD_W-2:0] shift_q, shift_d;
  logic [3:0]           cnt_q, cnt_d;

  always_comb begin
    word    = {shift_q, bit_in};
    done    = shift_en && (cnt_q == 4'd1);
    shift_d = shift_q;
    cnt_d   = cnt_q;
    // A reload discards the partial register and starts the next field.
    if (load) begin
      shift_d = '0;
      cnt_d   = len;
    end else if (shift_en) begin
      shift_d = word[PM_WORD_W-2:0];
      cnt_d   = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= 4'(PM_HDR_W);
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_mem_loader.sv
// Program/data memory that loads its image serially, then serves the core's split bus.
// Optional checksum trailer is compiled in with PROG_MEM_CHECKSUM_EN.
module prog_mem_loader
  import prog_mem_pkg::*;
#(
  parameter int WORD_W = 15,
  parameter int ADR_W  = 8
) (
  input  logic             ph1,
  input  logic             ph2,
  input  logic             reset,
  input  logic             sin_valid,
  input  logic             sin_bit,
  output logic             sin_ready,
  output logic             cpu_reset,
  output logic             loaded,
  output logic             error,
  input  logic [ADR_W-1:0] Adr,
  input  logic             MemWrite,
  output logic [6:0]       MemData1,
  inout  wire  [7:0]       MemData2
);

  localparam int CNT_W = ADR_W + 1;

  pm_state_t            state_q, state_d;
  logic [CNT_W-1:0]     word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]     n_q, n_d;
`ifdef PROG_MEM_CHECKSUM_EN
  logic [7:0]           csum_q, csum_d;
`endif

  logic                 fire;
  logic                 sh_load;
  logic [3:0]           sh_len;
  logic [PM_WORD_W-1:0] sh_word;
  logic                 sh_done;
  logic                 load_we;
  logic                 store_we;
  logic [ADR_W-1:0]     wr_adr;
  logic [WORD_W-1:0]    rd_word;
  logic                 md2_drive;
  logic [7:0]           md2_out;
  logic [WORD_W-1:0]    mem_q [2**ADR_W];

  // Serial port: a bit transfers on a ph1 edge where sin_valid && sin_ready; sin_ready
  // depends only on state, and sin_valid low simply stalls every counter.
  ser_shift u_shift (
    .clk      (ph1),
    .reset    (reset),
    .load     (sh_load),
    .len      (sh_len),
    .shift_en (fire),
    .bit_in   (sin_bit),
    .word     (sh_word),
    .done     (sh_done)
  );

  always_ff @(posedge ph1) begin
    if (reset) begin
      state_q    <= HDR;
      word_cnt_q <= '0;
      n_q        <= '0;
`ifdef PROG_MEM_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      n_q        <= n_d;
`ifdef PROG_MEM_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    n_d        = n_q;
`ifdef PROG_MEM_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    sh_load    = 1'b0;
    sh_len     = 4'(PM_WORD_W);
    load_we    = 1'b0;
    case (state_q)
      HDR: begin
        if (sh_done) begin
          // A zero header stands for a full-depth image.
          n_d        = (sh_word[PM_HDR_W-1:0] == '0) ? (CNT_W'(1) << ADR_W)
                                                     : CNT_W'(sh_word[PM_HDR_W-1:0]);
          word_cnt_d = '0;
          sh_load    = 1'b1;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (sh_done) begin
          load_we    = 1'b1;
          sh_load    = 1'b1;
          word_cnt_d = word_cnt_q + CNT_W'(1);
`ifdef PROG_MEM_CHECKSUM_EN
          csum_d     = csum_q + 8'(sh_word[14:8]) + sh_word[7:0];
`endif
          if (word_cnt_d == n_q) begin
`ifdef PROG_MEM_CHECKSUM_EN
            sh_len  = 4'(PM_CSUM_W);
            state_d = CSUM;
`else
            state_d = RUN;
`endif
          end
        end
      end
`ifdef PROG_MEM_CHECKSUM_EN
      CSUM: begin
        if (sh_done) begin
          state_d = (sh_word[PM_CSUM_W-1:0] == csum_q) ? RUN : ERR;
        end
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    sin_ready = (state_q == HDR) || (state_q == DATA) || (state_q == CSUM);
    fire      = sin_valid && sin_ready;
    cpu_reset = (state_q != RUN);
    loaded    = (state_q == RUN);
`ifdef PROG_MEM_CHECKSUM_EN
    error     = (state_q == ERR);
`else
    error     = 1'b0;
`endif
    wr_adr    = word_cnt_q[ADR_W-1:0];
    rd_word   = mem_q[Adr];
    // Outside RUN the bus reads as zero so the core decodes a harmless instruction.
    MemData1  = loaded ? rd_word[WORD_W-1:8] : '0;
    md2_out   = loaded ? rd_word[7:0] : '0;
    store_we  = loaded && MemWrite;
    md2_drive = !store_we;
  end

  assign MemData2 = md2_drive ? md2_out : 'z;

  // Writes land at the end of the cycle, after the core has settled the bus in phase 2.
  always_ff @(negedge ph2) begin
    if (!reset && load_we) begin
      mem_q[wr_adr] <= WORD_W'(sh_word);
    end else if (!reset && store_we) begin
      mem_q[Adr][7:0] <= MemData2;
    end
  end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: load, store, gaps, mid-load reset, full depth, checksum.
module tb_prog_mem_loader;

`ifdef PROG_MEM_CHECKSUM_EN
  localparam int CS_BITS = 8;
  logic [7:0] csum_adj = 8'h00;
`else
  localparam int CS_BITS = 0;
`endif

  logic       ph1 = 1'b0;
  logic       ph2 = 1'b0;
  logic       reset = 1'b1;
  logic       sin_valid = 1'b0;
  logic       sin_bit = 1'b0;
  logic       MemWrite = 1'b0;
  logic [7:0] Adr = 8'h00;
  logic [7:0] cpu_d = 8'h00;
  logic       cpu_drv = 1'b0;
  logic       sin_ready, cpu_reset, loaded, error;
  logic [6:0] MemData1;
  wire  [7:0] MemData2;

  int         checks = 0;
  int         errors = 0;
  logic [14:0] img [256];
  bit          bit_q[$];
  logic        rst_pre;
  int          cyc_n;

  assign MemData2 = cpu_drv ? cpu_d : 8'hzz;

  prog_mem_loader dut (
    .ph1       (ph1),
    .ph2       (ph2),
    .reset     (reset),
    .sin_valid (sin_valid),
    .sin_bit   (sin_bit),
    .sin_ready (sin_ready),
    .cpu_reset (cpu_reset),
    .loaded    (loaded),
    .error     (error),
    .Adr       (Adr),
    .MemWrite  (MemWrite),
    .MemData1  (MemData1),
    .MemData2  (MemData2)
  );

  // Clock and reset: non-overlapping two-phase clock, period 10.
  initial begin
    forever begin
      #1 ph1 = 1'b1;
      #4 ph1 = 1'b0;
      #1 ph2 = 1'b1;
      #3 ph2 = 1'b0;
      #1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge ph1);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sin_valid = 1'b0;
    MemWrite = 1'b0;
    cpu_drv = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Driver: header, words img[0..n-1], optional checksum; stop_after >= 0 truncates the stream.
  task automatic load_image(input int hdr, input int n, input bit gaps, input int stop_after,
                            output logic rst_before_last, output int cycles);
    logic [7:0]  h;
    logic [7:0]  cs;
    logic [14:0] w;
    int          nbits;
    bit_q.delete();
    h = hdr[7:0];
    cs = 8'h00;
    for (int i = 7; i >= 0; i--) bit_q.push_back(h[i]);
    for (int k = 0; k < n; k++) begin
      w = img[k];
      cs = cs + 8'(w[14:8]) + w[7:0];
      for (int i = 14; i >= 0; i--) bit_q.push_back(w[i]);
    end
`ifdef PROG_MEM_CHECKSUM_EN
    cs = cs + csum_adj;
    for (int i = 7; i >= 0; i--) bit_q.push_back(cs[i]);
`endif
    nbits = (stop_after >= 0) ? stop_after : bit_q.size();
    cycles = 0;
    rst_before_last = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      if (gaps) begin
        sin_valid = 1'b0;
        sin_bit = 1'($urandom_range(0, 1));
        cyc();
        cycles++;
      end
      if (b == nbits - 1) rst_before_last = cpu_reset;
      sin_valid = 1'b1;
      sin_bit = bit_q[b];
      cyc();
      cycles++;
    end
    sin_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    Adr = 8'h00;
    #1;
    checks++; if (sin_ready !== 1'b1) begin errors++; $display("FAIL rst_sin_ready got %b exp 1", sin_ready); end
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset got %b exp 1", cpu_reset); end
    checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL rst_loaded got %b exp 0", loaded); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error got %b exp 0", error); end
    checks++; if (MemData1 !== 7'h00) begin errors++; $display("FAIL rst_md1 got %h exp 00", MemData1); end
    checks++; if (MemData2 !== 8'h00) begin errors++; $display("FAIL rst_md2 got %h exp 00", MemData2); end
  endtask

  task automatic test_basic_load();
    img[0] = 15'h1234;
    img[1] = 15'h7FFF;
    load_image(2, 2, 1'b0, -1, rst_pre, cyc_n);
    checks++; if (rst_pre !== 1'b1) begin errors++; $display("FAIL basic_rst_before_last got %b exp 1", rst_pre); end
    checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL basic_cpu_reset got %b exp 0", cpu_reset); end
    checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL basic_loaded got %b exp 1", loaded); end
    checks++; if (sin_ready !== 1'b0) begin errors++; $display("FAIL basic_sin_ready got %b exp 0", sin_ready); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL basic_error got %b exp 0", error); end
    checks++; if (cyc_n !== 38 + CS_BITS) begin errors++; $display("FAIL basic_bits got %0d exp %0d", cyc_n, 38 + CS_BITS); end
    Adr = 8'd0; #1;
    checks++; if (MemData1 !== 7'h12) begin errors++; $display("FAIL basic_a0_md1 got %h exp 12", MemData1); end
    checks++; if (MemData2 !== 8'h34) begin errors++; $display("FAIL basic_a0_md2 got %h exp 34", MemData2); end
    Adr = 8'd1; #1;
    checks++; if (MemData1 !== 7'h7F) begin errors++; $display("FAIL basic_a1_md1 got %h exp 7f", MemData1); end
    checks++; if (MemData2 !== 8'hFF) begin errors++; $display("FAIL basic_a1_md2 got %h exp ff", MemData2); end
    // Bits offered in RUN must not disturb anything.
    for (int i = 0; i < 20; i++) begin
      sin_valid = 1'b1;
      sin_bit = i[0];
      cyc();
    end
    sin_valid = 1'b0;
    Adr = 8'd0; #1;
    checks++; if (MemData2 !== 8'h34) begin errors++; $display("FAIL run_ignore_md2 got %h exp 34", MemData2); end
    checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL run_ignore_loaded got %b exp 1", loaded); end
  endtask

  task automatic test_store();
    cyc();
    Adr = 8'd1;
    MemWrite = 1'b1;
    cpu_drv = 1'b1;
    cpu_d = 8'hA5;
    #1;
    // Any drive from the memory (0xFF at this address) would corrupt the bus value.
    checks++; if (MemData2 !== 8'hA5) begin errors++; $display("FAIL store_bus got %h exp a5", MemData2); end
    cyc();
    MemWrite = 1'b0;
    cpu_drv = 1'b0;
    #1;
    checks++; if (MemData1 !== 7'h7F) begin errors++; $display("FAIL store_md1 got %h exp 7f", MemData1); end
    checks++; if (MemData2 !== 8'hA5) begin errors++; $display("FAIL store_md2 got %h exp a5", MemData2); end
    Adr = 8'd0; #1;
    checks++; if (MemData2 !== 8'h34) begin errors++; $display("FAIL store_other_md2 got %h exp 34", MemData2); end
  endtask

  task automatic test_gaps();
    do_reset();
    img[0] = 15'h1234;
    img[1] = 15'h7FFF;
    load_image(2, 2, 1'b1, -1, rst_pre, cyc_n);
    checks++; if (rst_pre !== 1'b1) begin errors++; $display("FAIL gaps_rst_before_last got %b exp 1", rst_pre); end
    checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL gaps_cpu_reset got %b exp 0", cpu_reset); end
    checks++; if (cyc_n !== 2 * (38 + CS_BITS)) begin errors++; $display("FAIL gaps_cycles got %0d exp %0d", cyc_n, 2 * (38 + CS_BITS)); end
    Adr = 8'd1; #1;
    checks++; if (MemData1 !== 7'h7F) begin errors++; $display("FAIL gaps_a1_md1 got %h exp 7f", MemData1); end
    checks++; if (MemData2 !== 8'hFF) begin errors++; $display("FAIL gaps_a1_md2 got %h exp ff", MemData2); end
    Adr = 8'd0; #1;
    checks++; if (MemData1 !== 7'h12) begin errors++; $display("FAIL gaps_a0_md1 got %h exp 12", MemData1); end
    checks++; if (MemData2 !== 8'h34) begin errors++; $display("FAIL gaps_a0_md2 got %h exp 34", MemData2); end
  endtask

  task automatic test_reset_mid_data();
    do_reset();
    img[0] = 15'h2AAA;
    img[1] = 15'h5555;
    img[2] = 15'h1111;
    load_image(3, 3, 1'b0, 20, rst_pre, cyc_n);
    checks++; if (sin_ready !== 1'b1) begin errors++; $display("FAIL mid_sin_ready got %b exp 1", sin_ready); end
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL mid_cpu_reset got %b exp 1", cpu_reset); end
    do_reset();
    // A store strobe outside RUN must be ignored while the bus reads zero.
    MemWrite = 1'b1;
    Adr = 8'd1;
    #1;
    checks++; if (MemData2 !== 8'h00) begin errors++; $display("FAIL hdr_store_md2 got %h exp 00", MemData2); end
    checks++; if (MemData1 !== 7'h00) begin errors++; $display("FAIL hdr_store_md1 got %h exp 00", MemData1); end
    cyc();
    MemWrite = 1'b0;
    img[0] = 15'h0155;
    load_image(1, 1, 1'b0, -1, rst_pre, cyc_n);
    checks++; if (rst_pre !== 1'b1) begin errors++; $display("FAIL mid_rst_before_last got %b exp 1", rst_pre); end
    checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL mid_cpu_reset_after got %b exp 0", cpu_reset); end
    checks++; if (cyc_n !== 23 + CS_BITS) begin errors++; $display("FAIL mid_bits got %0d exp %0d", cyc_n, 23 + CS_BITS); end
    Adr = 8'd0; #1;
    checks++; if (MemData1 !== 7'h01) begin errors++; $display("FAIL mid_a0_md1 got %h exp 01", MemData1); end
    checks++; if (MemData2 !== 8'h55) begin errors++; $display("FAIL mid_a0_md2 got %h exp 55", MemData2); end
    Adr = 8'd1; #1;
    checks++; if (MemData1 !== 7'h7F) begin errors++; $display("FAIL mid_a1_md1 got %h exp 7f", MemData1); end
    checks++; if (MemData2 !== 8'hFF) begin errors++; $display("FAIL mid_a1_md2 got %h exp ff", MemData2); end
  endtask

  task automatic test_full_depth();
    do_reset();
    for (int k = 0; k < 256; k++) img[k] = 15'(k);
    load_image(0, 256, 1'b0, -1, rst_pre, cyc_n);
    checks++; if (rst_pre !== 1'b1) begin errors++; $display("FAIL full_rst_before_last got %b exp 1", rst_pre); end
    checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL full_cpu_reset got %b exp 0", cpu_reset); end
    checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL full_loaded got %b exp 1", loaded); end
    checks++; if (cyc_n !== 3848 + CS_BITS) begin errors++; $display("FAIL full_bits got %0d exp %0d", cyc_n, 3848 + CS_BITS); end
    Adr = 8'd255; #1;
    checks++; if (MemData1 !== 7'h00) begin errors++; $display("FAIL full_a255_md1 got %h exp 00", MemData1); end
    checks++; if (MemData2 !== 8'hFF) begin errors++; $display("FAIL full_a255_md2 got %h exp ff", MemData2); end
    Adr = 8'd128; #1;
    checks++; if (MemData2 !== 8'h80) begin errors++; $display("FAIL full_a128_md2 got %h exp 80", MemData2); end
    Adr = 8'd0; #1;
    checks++; if (MemData2 !== 8'h00) begin errors++; $display("FAIL full_a0_md2 got %h exp 00", MemData2); end
    sin_valid = 1'b1;
    sin_bit = 1'b1;
    cyc();
    cyc();
    sin_valid = 1'b0;
    checks++; if (sin_ready !== 1'b0) begin errors++; $display("FAIL full_sin_ready got %b exp 0", sin_ready); end
    checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL full_loaded_after got %b exp 1", loaded); end
  endtask

`ifdef PROG_MEM_CHECKSUM_EN
  task automatic test_checksum_err();
    do_reset();
    img[0] = 15'h1234;
    img[1] = 15'h7FFF;
    csum_adj = 8'h01;
    load_image(2, 2, 1'b0, -1, rst_pre, cyc_n);
    csum_adj = 8'h00;
    Adr = 8'd0; #1;
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL csum_error got %b exp 1", error); end
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL csum_cpu_reset got %b exp 1", cpu_reset); end
    checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL csum_loaded got %b exp 0", loaded); end
    checks++; if (sin_ready !== 1'b0) begin errors++; $display("FAIL csum_sin_ready got %b exp 0", sin_ready); end
    checks++; if (MemData2 !== 8'h00) begin errors++; $display("FAIL csum_md2 got %h exp 00", MemData2); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_store();
    test_gaps();
    test_reset_mid_data();
    test_full_depth();
`ifdef PROG_MEM_CHECKSUM_EN
    test_checksum_err();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
